// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the transmit FIFO read port and sends
// each one as an LSB-first UART frame on tx. Frames run back-to-back while
// the FIFO is non-empty.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Without it, frames are 8N1.
//
//   state  | meaning
//   IDLE   | line high; pop FIFO when non-empty
//   FETCH  | FIFO data valid; capture byte, clear counters
//   START  | start bit (tx = 0)
//   DATA   | data bits, LSB first
//   PARITY | even parity bit (UART_TX_PARITY_EN only)
//   STOP   | stop bit (tx = 1); tx_done on its final cycle
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_W) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_START, ST_DATA, ST_PARITY, ST_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_START, ST_DATA, ST_STOP
   } state_t;
`endif

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                tx_d;
   logic                bit_end;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   assign bit_end = (baud_q == BAUD_LAST);
   assign busy    = (state_q != ST_IDLE);

   // State, counters, shift register and registered tx line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx       <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state, counter updates, pop strobe and tx_done.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      fifo_rd_en = 1'b0;
      tx_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Gated by rst_n so no pop is requested while held in reset.
            fifo_rd_en = rst_n & ~fifo_empty;
            if (!fifo_empty) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            shift_d  = fifo_data;
            baud_d   = '0;
            bit_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
            state_d  = ST_START;
         end
         ST_START: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
               if (bit_q == BIT_LAST) state_d = ST_PARITY;
`else
               if (bit_q == BIT_LAST) state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            baud_d  = bit_end ? '0 : baud_q + 1'b1;
            tx_done = bit_end;
            if (bit_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level for the upcoming cycle, decoded from the next state so tx
   // can be registered without adding a cycle of latency.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Downstream stage of the UART transmit FIFO: pops bytes from the synchronous FIFO's read port and serializes each as an 8N1 UART frame on `tx`. Bit timing comes from an internal clocks-per-bit counter. Frames are sent LSB first, back-to-back while the FIFO is non-empty. An optional even-parity bit is compiled in by macro.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit; legal range ≥ 2.
- `DATA_W`, default 8: data bits per frame; must equal the FIFO width.
- `clk`  input  1  clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_data`  input  DATA_W  FIFO `data_out`; registered, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  output  1  FIFO pop strobe, one cycle per byte.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high whenever state ≠ IDLE.
- `tx_done`  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, FETCH, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - `fifo_rd_en = !fifo_empty` (combinational, asserted only in IDLE).
  - If `!fifo_empty`, go to FETCH next cycle. Otherwise stay.
- FETCH (1 cycle): `fifo_data` is valid. Load it into the shift register, clear the bit and baud counters, go to START.
- START: `tx = 0` for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx = shift[0]`. After each CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATA_W bits, go to PARITY (macro) or STOP.
- PARITY: `tx = ^byte` (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx = 1` for CLKS_PER_BIT cycles. `tx_done` is high on the final cycle. Then go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit counter is `$clog2(DATA_W)+1` bits wide.
- `tx` is a registered output, so there are no glitches.
- The byte is captured at FETCH; later FIFO writes or changes on `fifo_data` do not affect the frame in flight.

## Timing
- Reset values: `tx = 1`, `busy = 0`, `tx_done = 0`, `fifo_rd_en = 0`, state IDLE, all counters 0.
- Reset mid-frame: `tx` returns to 1 asynchronously and the frame is abandoned. After reset is released, the next pop happens only on a fresh IDLE evaluation.
- Latency from `fifo_empty` falling (while IDLE) to `tx` falling: 2 cycles (IDLE with rd_en, then FETCH).
- Frame length: (DATA_W+2)·CLKS_PER_BIT cycles, or (DATA_W+3)·CLKS_PER_BIT with parity.
- Back-to-back frames: between consecutive frames, `tx` stays high for exactly CLKS_PER_BIT+2 cycles (stop bit plus IDLE plus FETCH).
- Exactly one `fifo_rd_en` pulse per frame. No pop occurs outside IDLE, even if `fifo_empty` toggles mid-frame.
- FIFO empty at the end of STOP: remain IDLE with `tx = 1` and `busy = 0` on the next cycle.
- `fifo_empty` deasserting in the same cycle STOP ends: it is sampled in IDLE on the following cycle. No frame is lost.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and frames are 8E1. The parity bit equals the XOR of the data bits (even parity).
- `UART_TX_PARITY_EN` undefined: the PARITY state, its logic and its counter decode are absent. Frames are 8N1 and STOP directly follows DATA.

## Test plan
- Reset with `fifo_empty = 1`, CLKS_PER_BIT = 4: `tx = 1`, `busy = 0`, no `fifo_rd_en` for 100 cycles.
- Pop 0xA5, CLKS_PER_BIT = 4, no macro:
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total).
  - `tx_done` pulses at cycle 40 after START entry.
  - Exactly one `fifo_rd_en`.
- FIFO preloaded with 0x00, 0xFF, 0x3C:
  - Three frames decoded correctly.
  - Inter-frame high gap is 6 cycles.
  - 3 `fifo_rd_en` pulses in total; `busy` drops 1 cycle after the third `tx_done`.
- With `UART_TX_PARITY_EN`, send 0x07 then 0x03: parity bit is 1 then 0; frame length is 11·CLKS_PER_BIT.
- Assert `rst_n = 0` during DATA bit 3 of 0x55: `tx` goes to 1 immediately and `busy = 0`. After release with the FIFO non-empty, a complete new frame starts from START.
- Toggle `fifo_empty` and change `fifo_data` mid-frame: no extra `fifo_rd_en` is issued and the transmitted byte is unchanged.
